// File: rtl/ad7609_frame_fifo.sv
// rtl/ad7609_frame_fifo.sv - frame FIFO for AD7609 channel snapshots, streamed one word per handshake
// Whole eight-channel frames are stored per entry; a shift register serialises ch0..ch7.
module ad7609_frame_fifo #(
  parameter int DATA_W = 16,
  parameter int AW     = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Value1,
  input  logic [DATA_W-1:0] Value2,
  input  logic [DATA_W-1:0] Value3,
  input  logic [DATA_W-1:0] Value4,
  input  logic [DATA_W-1:0] Value5,
  input  logic [DATA_W-1:0] Value6,
  input  logic [DATA_W-1:0] Value7,
  input  logic [DATA_W-1:0] Value8,
  input  logic              Frame_valid,
  output logic [DATA_W-1:0] Dout,
  output logic [2:0]        Dout_ch,
  output logic              Dout_last,
  output logic              Dout_valid,
  input  logic              Dout_ready,
  output logic [AW:0]       Frame_count,
  output logic              Overflow,
  output logic [7:0]        Drop_cnt,
  input  logic              Clr_ovf
);

  localparam int DEPTH = 1 << AW;
  localparam int FW    = 8 * DATA_W;

  typedef enum logic {IDLE, SEND} state_t;

  logic [FW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [FW-1:0] sreg;
  logic [2:0]    ch;
  logic          valid_q;
  state_t        state, state_nxt;

  logic empty, full, accept, pop, shift, wr, drop;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign accept = valid_q && Dout_ready;

  // A pop in the same cycle frees the slot the write lands in (read happens before the edge).
  assign wr   = Frame_valid && (!full || pop);
  assign drop = Frame_valid && full && !pop;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!empty) state_nxt = SEND;
      SEND: if (accept && (ch == 3'd7) && empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE: pop = !empty;
      SEND: begin
        if (accept) begin
          if (ch != 3'd7) shift = 1'b1;
          else            pop   = !empty;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (wr && !Rst)
      mem[wptr[AW-1:0]] <= {Value8, Value7, Value6, Value5, Value4, Value3, Value2, Value1};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr    <= '0;
      rptr    <= '0;
      sreg    <= '0;
      ch      <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + (AW+1)'(1);
      if (pop) begin
        sreg    <= mem[rptr[AW-1:0]];
        rptr    <= rptr + (AW+1)'(1);
        ch      <= '0;
        valid_q <= 1'b1;
      end else if (shift) begin
        sreg <= sreg >> DATA_W;
        ch   <= ch + 3'd1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Overflow <= 1'b0;
      Drop_cnt <= '0;
    end else if (drop) begin
      Overflow <= 1'b1;
      if (Clr_ovf)                Drop_cnt <= 8'd1;
      else if (Drop_cnt != 8'hFF) Drop_cnt <= Drop_cnt + 8'd1;
    end else if (Clr_ovf) begin
      Overflow <= 1'b0;
      Drop_cnt <= '0;
    end
  end

  assign Dout        = sreg[DATA_W-1:0];
  assign Dout_ch     = ch;
  assign Dout_last   = valid_q && (ch == 3'd7);
  assign Dout_valid  = valid_q;
  assign Frame_count = wptr - rptr;

endmodule

// File: tb/tb_ad7609_frame_fifo.sv
// tb/tb_ad7609_frame_fifo.sv - directed self-checking bench for ad7609_frame_fifo
module tb_ad7609_frame_fifo;

  localparam int DATA_W = 16;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] v [8];
  logic              frame_valid;
  logic [DATA_W-1:0] dout;
  logic [2:0]        dout_ch;
  logic              dout_last;
  logic              dout_valid;
  logic              dout_ready;
  logic [AW:0]       frame_count;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              clr_ovf;

  ad7609_frame_fifo #(.DATA_W(DATA_W), .AW(AW)) dut (
    .Clk(clk), .Rst(rst),
    .Value1(v[0]), .Value2(v[1]), .Value3(v[2]), .Value4(v[3]),
    .Value5(v[4]), .Value6(v[5]), .Value7(v[6]), .Value8(v[7]),
    .Frame_valid(frame_valid),
    .Dout(dout), .Dout_ch(dout_ch), .Dout_last(dout_last),
    .Dout_valid(dout_valid), .Dout_ready(dout_ready),
    .Frame_count(frame_count), .Overflow(overflow), .Drop_cnt(drop_cnt),
    .Clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_values(input logic [15:0] base);
    for (int k = 0; k < 8; k++) v[k] = base + 16'(k + 1);
  endtask

  task automatic queue_frame(input logic [15:0] base);
    for (int k = 0; k < 8; k++) exp_q.push_back(base + 16'(k + 1));
  endtask

  task automatic push(input logic [15:0] base);
    load_values(base);
    frame_valid = 1'b1;
    tick;
    frame_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, 32'(dout), 0);
    check({tag, "_ch"}, 32'(dout_ch), 0);
    check({tag, "_last"}, 32'(dout_last), 0);
    check({tag, "_valid"}, 32'(dout_valid), 0);
    check({tag, "_count"}, 32'(frame_count), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_drop"}, 32'(drop_cnt), 0);
  endtask

  // Accepts every word in exp_q; toggle alternates ready, no_bubble flags any gap once streaming.
  task automatic consume(input bit toggle, input bit no_bubble, output int cycles);
    int idx;
    bit started, held;
    logic [15:0] hd, w;
    logic [2:0] hc;
    idx = 0; started = 0; held = 0; hd = '0; hc = '0;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 400) begin
      dout_ready = toggle ? (cycles % 2 == 0) : 1'b1;
      if (held) begin
        check("hold_valid", 32'(dout_valid), 1);
        check("hold_data", 32'(dout), 32'(hd));
        check("hold_ch", 32'(dout_ch), 32'(hc));
      end
      if (no_bubble && started) check("bubble", 32'(dout_valid), 1);
      if (dout_valid) started = 1;
      held = dout_valid && !dout_ready;
      hd = dout;
      hc = dout_ch;
      if (dout_valid && dout_ready) begin
        w = exp_q.pop_front();
        check("word_data", 32'(dout), 32'(w));
        check("word_ch", 32'(dout_ch), 32'(idx % 8));
        check("word_last", 32'(dout_last), 32'(idx % 8 == 7));
        idx++;
      end
      tick;
      cycles++;
    end
    if (exp_q.size() > 0) begin
      check("consume_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    dout_ready = 1'b0;
  endtask

  initial begin
    int c, w;
    rst = 1'b1; frame_valid = 1'b0; dout_ready = 1'b0; clr_ovf = 1'b0;
    for (int k = 0; k < 8; k++) v[k] = '0;
    tick; tick;
    rst = 1'b0;
    check_outputs_zero("reset");

    // T1 single frame, first word two edges after the strobe
    push(16'h1000);
    check("t1_lat_n1", 32'(dout_valid), 0);
    tick;
    check("t1_lat_n2", 32'(dout_valid), 1);
    check("t1_first", 32'(dout), 32'h1001);
    check("t1_first_ch", 32'(dout_ch), 0);
    queue_frame(16'h1000);
    consume(1'b0, 1'b1, c);
    check("t1_cycles", 32'(c), 8);
    check("t1_idle", 32'(dout_valid), 0);
    check("t1_last_idle", 32'(dout_last), 0);

    // T2 backpressure
    push(16'h1100);
    queue_frame(16'h1100);
    consume(1'b1, 1'b0, c);
    check("t2_idle", 32'(dout_valid), 0);

    // T3 overflow: one frame streaming, four stored, two dropped
    for (int f = 0; f < 7; f++) push(16'h2000 + 16'(f * 16));
    check("t3_count", 32'(frame_count), 4);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_drop", 32'(drop_cnt), 2);
    check("t3_held", 32'(dout), 32'h2001);
    clr_ovf = 1'b1;
    push(16'h2080);
    clr_ovf = 1'b0;
    check("t3_clrdrop_ovf", 32'(overflow), 1);
    check("t3_clrdrop_cnt", 32'(drop_cnt), 1);
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    check("t3_clr_ovf", 32'(overflow), 0);
    check("t3_clr_drop", 32'(drop_cnt), 0);

    // T4 full FIFO, new frame coincident with the last-word accept
    for (int k = 0; k < 8; k++) begin
      check("t4_data", 32'(dout), 32'h2000 + 32'(k + 1));
      check("t4_ch", 32'(dout_ch), 32'(k));
      dout_ready = 1'b1;
      if (k == 7) begin
        load_values(16'h2070);
        frame_valid = 1'b1;
      end
      tick;
    end
    frame_valid = 1'b0;
    dout_ready = 1'b0;
    check("t4_ovf", 32'(overflow), 0);
    check("t4_drop", 32'(drop_cnt), 0);
    check("t4_count", 32'(frame_count), 4);
    check("t4_next_valid", 32'(dout_valid), 1);
    check("t4_next_data", 32'(dout), 32'h2011);
    check("t4_next_ch", 32'(dout_ch), 0);
    queue_frame(16'h2010); queue_frame(16'h2020); queue_frame(16'h2030);
    queue_frame(16'h2040); queue_frame(16'h2070);
    consume(1'b0, 1'b1, c);
    check("t4_drain_cycles", 32'(c), 40);
    check("t4_empty", 32'(frame_count), 0);

    // T5 back-to-back frames
    push(16'h3100); push(16'h3200); push(16'h3300);
    queue_frame(16'h3100); queue_frame(16'h3200); queue_frame(16'h3300);
    consume(1'b0, 1'b1, c);
    check("t5_cycles", 32'(c), 24);
    check("t5_idle", 32'(dout_valid), 0);

    // T6 reset mid-stream at ch3, with a coincident strobe that must be ignored
    push(16'h4000);
    dout_ready = 1'b1;
    w = 0;
    while (!dout_valid && w < 10) begin tick; w++; end
    check("t6_start", 32'(dout_valid), 1);
    for (int k = 0; k < 3; k++) begin
      check("t6_pre_data", 32'(dout), 32'h4000 + 32'(k + 1));
      tick;
    end
    check("t6_at_ch3", 32'(dout_ch), 3);
    rst = 1'b1;
    load_values(16'h4800);
    frame_valid = 1'b1;
    tick;
    rst = 1'b0;
    frame_valid = 1'b0;
    dout_ready = 1'b0;
    check_outputs_zero("t6_rst");
    tick; tick; tick;
    check("t6_ignored_valid", 32'(dout_valid), 0);
    check("t6_ignored_count", 32'(frame_count), 0);
    push(16'h5000);
    queue_frame(16'h5000);
    consume(1'b0, 1'b1, c);
    check("t6_idle", 32'(dout_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
